// File: rtl/cnn_pkg.sv
// Shared fp16 constants, types and the collector state encoding for the CNN datapath stages.
package cnn_pkg;

    localparam int DATA_WIDTH = 16;

    localparam logic [15:0] FP16_EXP_MASK = 16'h7C00;
    localparam logic [15:0] FP16_MAN_MASK = 16'h03FF;

    typedef logic [15:0] fp16_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/fp16_relu.sv
// Combinational fp16 ReLU: negatives (incl. -0, -Inf, -NaN) and positive NaN map to +0.
module fp16_relu
    import cnn_pkg::*;
(
    input  fp16_t x_i,
    output fp16_t y_o
);

    logic is_neg;
    logic is_nan;

    always_comb begin
        is_neg = x_i[15];
        is_nan = ((x_i & FP16_EXP_MASK) == FP16_EXP_MASK) && ((x_i & FP16_MAN_MASK) != '0);
        y_o    = (is_neg || is_nan) ? fp16_t'('0) : x_i;
    end

endmodule

// File: rtl/fc_argmax_collector.sv
// Collects one fp16 neuron result per handshake, stores ReLU'd values and tracks the
// running argmax; presents class index and max activation once the layer completes.
module fc_argmax_collector #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_NEURONS = 10,
    parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              result_valid,
    input  logic [DATA_WIDTH-1:0]             neuron_result,
    output logic                              result_ready,
    output logic [NUM_NEURONS*DATA_WIDTH-1:0] relu_vec,
    output logic [IDX_W-1:0]                  class_idx,
    output logic [DATA_WIDTH-1:0]             max_value,
    output logic                              busy,
    output logic                              done,
    output logic                              overrun_err
);
    import cnn_pkg::*;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                cnt_q, cnt_d;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] vec_q, vec_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [DATA_WIDTH-1:0]           max_q, max_d;
    logic                            ovr_q, ovr_d;
    fp16_t                           rect;

    fp16_relu u_relu (
        .x_i (neuron_result),
        .y_o (rect)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        idx_d   = idx_q;
        max_d   = max_q;
        ovr_d   = ovr_q;

        // start wins over a coincident result beat, which is dropped
        if (start) begin
            state_d = COLLECT;
            cnt_d   = '0;
            vec_d   = '0;
            idx_d   = '0;
            max_d   = '0;
            ovr_d   = 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (result_valid) begin
                        vec_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = rect;
                        // values are non-negative after ReLU, so unsigned compare orders magnitudes
                        if ((cnt_q == '0) || (rect[DATA_WIDTH-2:0] > max_q[DATA_WIDTH-2:0])) begin
                            max_d = rect;
                            idx_d = cnt_q;
                        end
                        if (cnt_q == IDX_W'(NUM_NEURONS - 1)) begin
                            cnt_d   = '0;
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (result_valid) ovr_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            idx_q   <= '0;
            max_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
            ovr_q   <= ovr_d;
        end
    end

    assign result_ready = (state_q == COLLECT);
    assign busy         = (state_q == COLLECT);
    assign done         = (state_q == DONE);
    assign relu_vec     = vec_q;
    assign class_idx    = idx_q;
    assign max_value    = max_q;
    assign overrun_err  = ovr_q;

endmodule

// File: tb/tb_fc_argmax_collector.sv
// Directed bench for fc_argmax_collector with hand-computed expected results.
module tb_fc_argmax_collector;

    localparam int DW = 16;
    localparam int NN = 10;
    localparam int VW = NN * DW;

    logic          clk;
    logic          reset;
    logic          start;
    logic          result_valid;
    logic [DW-1:0] neuron_result;
    logic          result_ready;
    logic [VW-1:0] relu_vec;
    logic [3:0]    class_idx;
    logic [DW-1:0] max_value;
    logic          busy;
    logic          done;
    logic          overrun_err;

    int n_checks = 0;
    int n_pass   = 0;

    fc_argmax_collector #(
        .DATA_WIDTH  (DW),
        .NUM_NEURONS (NN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .result_valid  (result_valid),
        .neuron_result (neuron_result),
        .result_ready  (result_ready),
        .relu_vec      (relu_vec),
        .class_idx     (class_idx),
        .max_value     (max_value),
        .busy          (busy),
        .done          (done),
        .overrun_err   (overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [VW-1:0] pack(input logic [DW-1:0] v [NN]);
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < NN; i++) r[i*DW +: DW] = v[i];
        return r;
    endfunction

    task automatic pulse_start(input logic with_valid);
        @(negedge clk);
        start         = 1'b1;
        result_valid  = with_valid;
        neuron_result = 16'h7BFF;
        @(negedge clk);
        start        = 1'b0;
        result_valid = 1'b0;
        check("busy_after_start", VW'(busy), VW'(1'b1));
        check("ready_after_start", VW'(result_ready), VW'(1'b1));
    endtask

    // Presents the vector with `gap` idle cycles between beats; idle data would win if taken.
    task automatic feed(input logic [DW-1:0] v [NN], input int gap);
        for (int i = 0; i < NN; i++) begin
            result_valid  = 1'b1;
            neuron_result = v[i];
            if (i == NN - 1) check("done_before_last", VW'(done), VW'(1'b0));
            @(negedge clk);
            result_valid  = 1'b0;
            neuron_result = 16'h7BFF;
            if (i != NN - 1) begin
                for (int g = 0; g < gap; g++) begin
                    check("ready_in_gap", VW'(result_ready), VW'(1'b1));
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [DW-1:0] ev [NN],
                                input logic [3:0] eidx, input logic [DW-1:0] emax);
        check({tag, "_done"}, VW'(done), VW'(1'b1));
        check({tag, "_busy"}, VW'(busy), VW'(1'b0));
        check({tag, "_idx"}, VW'(class_idx), VW'(eidx));
        check({tag, "_max"}, VW'(max_value), VW'(emax));
        check({tag, "_vec"}, relu_vec, pack(ev));
    endtask

    logic [DW-1:0] v1 [NN];
    logic [DW-1:0] v2 [NN];
    logic [DW-1:0] v3 [NN];
    logic [DW-1:0] z  [NN];
    logic [DW-1:0] e3 [NN];

    initial begin
        v1 = '{16'h3C00, 16'h4000, 16'h3800, 16'h4200, 16'h0000,
               16'h4100, 16'h3E00, 16'h4200, 16'h3400, 16'h3000};
        v2 = '{16'hBC00, 16'hFE00, 16'h7E00, 16'h8000, 16'h8000,
               16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        for (int i = 0; i < NN; i++) begin
            z[i]  = 16'h0000;
            v3[i] = (i == 5) ? 16'h7C00 : 16'h7BFF;
        end
        e3 = v3;

        reset = 1'b1; start = 1'b0; result_valid = 1'b0; neuron_result = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_vec", relu_vec, '0);
        check("rst_idx", VW'(class_idx), '0);
        check("rst_max", VW'(max_value), '0);
        check("rst_busy", VW'(busy), '0);
        check("rst_ready", VW'(result_ready), '0);
        check("rst_done", VW'(done), '0);
        check("rst_ovr", VW'(overrun_err), '0);

        // result_valid in IDLE is ignored without an error
        result_valid = 1'b1; neuron_result = 16'h4000;
        @(negedge clk);
        result_valid = 1'b0;
        check("idle_vec", relu_vec, '0);
        check("idle_ovr", VW'(overrun_err), '0);

        pulse_start(1'b0);
        feed(v1, 0);
        check_result("b2b", v1, 4'd3, 16'h4200);

        pulse_start(1'b0);
        feed(v2, 0);
        check_result("neg", z, 4'd0, 16'h0000);

        pulse_start(1'b0);
        feed(v3, 0);
        check_result("inf", e3, 4'd5, 16'h7C00);

        pulse_start(1'b0);
        feed(v1, 2);
        check_result("thr", v1, 4'd3, 16'h4200);

        // restart mid-layer: large partial values must not survive
        pulse_start(1'b0);
        for (int i = 0; i < 4; i++) begin
            result_valid = 1'b1; neuron_result = 16'h7000;
            @(negedge clk);
        end
        result_valid = 1'b0;
        pulse_start(1'b1);
        feed(v1, 0);
        check_result("rst_layer", v1, 4'd3, 16'h4200);

        result_valid = 1'b1; neuron_result = 16'h7BFF;
        @(negedge clk);
        result_valid = 1'b0;
        check("ovr_set", VW'(overrun_err), VW'(1'b1));
        check_result("ovr_hold", v1, 4'd3, 16'h4200);
        @(negedge clk);
        check("ovr_sticky", VW'(overrun_err), VW'(1'b1));
        pulse_start(1'b0);
        check("ovr_clear", VW'(overrun_err), VW'(1'b0));

        // async reset between edges mid-collection
        for (int i = 0; i < 3; i++) begin
            result_valid = 1'b1; neuron_result = 16'h4400;
            @(negedge clk);
        end
        result_valid = 1'b0;
        check("pre_arst_vec0", VW'(relu_vec[DW-1:0]), VW'(16'h4400));
        #2 reset = 1'b1;
        #1;
        check("arst_vec", relu_vec, '0);
        check("arst_idx", VW'(class_idx), '0);
        check("arst_max", VW'(max_value), '0);
        check("arst_ready", VW'(result_ready), '0);
        check("arst_busy", VW'(busy), '0);
        @(negedge clk);
        reset = 1'b0;
        result_valid = 1'b1; neuron_result = 16'h4400;
        repeat (2) @(negedge clk);
        result_valid = 1'b0;
        check("post_arst_ready", VW'(result_ready), '0);
        check("post_arst_vec", relu_vec, '0);
        check("post_arst_done", VW'(done), '0);

        pulse_start(1'b0);
        feed(v3, 1);
        check_result("after_arst", e3, 4'd5, 16'h7C00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
